// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared pipeline definitions for the MEM stage.
// Provides the FSM state encoding, the timeout default and the counter sizing helper.
`default_nettype none

package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mau_state_e;

    localparam int TIMEOUT_DEFAULT = 15;

    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_ack.sv
// mem_ack_timer: counts WAIT cycles and flags the one on which the access must give up.
// The counter value is the number of WAIT cycles already completed.
`default_nettype none

module mem_ack_timer
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The TIMEOUT-th WAIT cycle is the last one allowed without an ack.
    assign expired = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage issuing one data-memory access at a time,
// stalling upstream until the ack (or a timeout) and producing the MEM/WB register.
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_rb,
    input  logic        mem_wmem,
    input  logic        mem_m2reg,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_rn,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rn,
    output logic        wb_wreg,
    output logic        bus_err
);

    mau_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [4:0]  rn_q;
    logic        we_q;
    logic        load_q;
    logic        abort_q;
    logic        req_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rn_q;
    logic        wb_wreg_q;
    logic        bus_err_q;

    logic mem_op;
    logic idle_mem_op;
    logic in_wait;
    logic expired;

    assign mem_op      = mem_wmem | mem_m2reg;
    assign idle_mem_op = (state_q == ST_IDLE) && mem_op;
    assign in_wait     = (state_q == ST_WAIT);

    mem_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .clr     (clr),
        .start   (idle_mem_op),
        .run     (in_wait),
        .expired (expired)
    );

    // The bus is forced quiet whenever no request is outstanding.
    assign dm_req   = req_q;
    assign dm_we    = req_q & we_q;
    assign dm_addr  = req_q ? addr_q  : 32'd0;
    assign dm_wdata = req_q ? wdata_q : 32'd0;

    assign stall    = !clr && (idle_mem_op || in_wait);
    assign wb_data  = wb_data_q;
    assign wb_rn    = wb_rn_q;
    assign wb_wreg  = wb_wreg_q;
    assign bus_err  = bus_err_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rn_q      <= '0;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            abort_q   <= 1'b0;
            req_q     <= 1'b0;
            wb_data_q <= '0;
            wb_rn_q   <= '0;
            wb_wreg_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_op) begin
                        addr_q    <= mem_result;
                        wdata_q   <= mem_rb;
                        we_q      <= mem_wmem;
                        load_q    <= mem_m2reg & ~mem_wmem;
                        rn_q      <= mem_rn;
                        abort_q   <= 1'b0;
                        req_q     <= 1'b1;
                        wb_wreg_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end else begin
                        wb_data_q <= mem_result;
                        wb_rn_q   <= mem_rn;
                        wb_wreg_q <= mem_wreg;
                    end
                end
                ST_WAIT: begin
                    // An ack arriving on the expiry cycle still completes the access.
                    if (dm_ack) begin
                        rdata_q <= dm_rdata;
                        req_q   <= 1'b0;
                        state_q <= ST_RESP;
                    end else if (expired) begin
                        rdata_q   <= '0;
                        abort_q   <= 1'b1;
                        bus_err_q <= 1'b1;
                        req_q     <= 1'b0;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (load_q && !abort_q) begin
                        wb_data_q <= rdata_q;
                        wb_rn_q   <= rn_q;
                        wb_wreg_q <= 1'b1;
                    end else begin
                        wb_wreg_q <= 1'b0;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scenario tasks plus randomized traffic, checked against a
// transaction-level model of access latency, writeback and the sticky bus error.
`default_nettype none

module tb_mem_access_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] mem_result;
    logic [31:0] mem_rb;
    logic        mem_wmem;
    logic        mem_m2reg;
    logic        mem_wreg;
    logic [4:0]  mem_rn;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_rn;
    logic        wb_wreg;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .clr        (clr),
        .mem_result (mem_result),
        .mem_rb     (mem_rb),
        .mem_wmem   (mem_wmem),
        .mem_m2reg  (mem_m2reg),
        .mem_wreg   (mem_wreg),
        .mem_rn     (mem_rn),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .stall      (stall),
        .wb_data    (wb_data),
        .wb_rn      (wb_rn),
        .wb_wreg    (wb_wreg),
        .bus_err    (bus_err)
    );

    task automatic set_nop();
        mem_result = $urandom;
        mem_rb     = $urandom;
        mem_wmem   = 1'b0;
        mem_m2reg  = 1'b0;
        mem_wreg   = 1'b0;
        mem_rn     = 5'($urandom);
    endtask

    // Memory-op-looking inputs that a busy stage must ignore.
    task automatic drive_junk();
        mem_result = $urandom;
        mem_rb     = $urandom;
        mem_wmem   = 1'b1;
        mem_m2reg  = 1'($urandom_range(0, 1));
        mem_wreg   = 1'b1;
        mem_rn     = 5'($urandom);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        dm_ack = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        drive_junk();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, stall, wb_data, wb_rn, wb_wreg, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h stall=%b wb_data=%h wb_rn=%0d wb_wreg=%b bus_err=%b, all required 0",
                     dm_req, dm_we, dm_addr, dm_wdata, stall, wb_data, wb_rn, wb_wreg, bus_err);
        end
        clr = 1'b0;
        dm_ack = 1'b0;
        set_nop();
        exp_err = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] res, input logic [4:0] rn, input logic wreg, input logic stray_ack);
        @(posedge clk); #1;
        mem_result = res;
        mem_rb     = $urandom;
        mem_wmem   = 1'b0;
        mem_m2reg  = 1'b0;
        mem_wreg   = wreg;
        mem_rn     = rn;
        dm_ack     = stray_ack;
        dm_rdata   = $urandom;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL alu_no_stall: stall=%b dm_req=%b, required 0 and 0", stall, dm_req);
        end
        @(posedge clk); #1;
        set_nop();
        dm_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_data !== res || wb_rn !== rn || wb_wreg !== wreg || bus_err !== exp_err) begin
            errors++;
            $display("FAIL alu_wb: wb_data=%h wb_rn=%0d wb_wreg=%b bus_err=%b, required %h %0d %b %b",
                     wb_data, wb_rn, wb_wreg, bus_err, res, rn, wreg, exp_err);
        end
    endtask

    // ack_at: WAIT cycle (1-based) on which dm_ack is raised; 0 or >TO means never.
    task automatic mem_op(input logic [31:0] addr, input logic [31:0] data, input logic store,
                          input logic [4:0] rn, input int ack_at, input logic [31:0] rdata);
        logic acked;
        int   n_wait;
        logic err_before;
        acked      = (ack_at >= 1) && (ack_at <= TO);
        n_wait     = acked ? ack_at : TO;
        err_before = exp_err;
        @(posedge clk); #1;
        mem_result = addr;
        mem_rb     = data;
        mem_wmem   = store;
        mem_m2reg  = store ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_wreg   = 1'($urandom_range(0, 1));
        mem_rn     = rn;
        dm_ack     = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL mem_issue: stall=%b dm_req=%b, required 1 and 0", stall, dm_req);
        end
        for (int k = 1; k <= n_wait; k++) begin
            @(posedge clk); #1;
            drive_junk();
            dm_ack   = (k == ack_at);
            dm_rdata = (k == ack_at) ? rdata : $urandom;
            @(negedge clk);
            checks++;
            if (stall !== 1'b1 || dm_req !== 1'b1 || dm_addr !== addr || dm_we !== store
                || dm_wdata !== data || bus_err !== err_before) begin
                errors++;
                $display("FAIL mem_wait%0d: stall=%b req=%b addr=%h we=%b wdata=%h err=%b, required 1 1 %h %b %h %b",
                         k, stall, dm_req, dm_addr, dm_we, dm_wdata, bus_err, addr, store, data, err_before);
            end
        end
        if (!acked) exp_err = 1'b1;
        @(posedge clk); #1;
        dm_ack   = 1'($urandom_range(0, 1));
        dm_rdata = $urandom;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || dm_req !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 32'd0
            || dm_wdata !== 32'd0 || wb_wreg !== 1'b0 || bus_err !== exp_err) begin
            errors++;
            $display("FAIL mem_resp: stall=%b req=%b we=%b addr=%h wdata=%h wb_wreg=%b err=%b, required 0 0 0 0 0 0 %b",
                     stall, dm_req, dm_we, dm_addr, dm_wdata, wb_wreg, bus_err, exp_err);
        end
        @(posedge clk); #1;
        set_nop();
        dm_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (!store && acked) begin
            if (wb_wreg !== 1'b1 || wb_data !== rdata || wb_rn !== rn || stall !== 1'b0) begin
                errors++;
                $display("FAIL load_wb: wb_wreg=%b wb_data=%h wb_rn=%0d stall=%b, required 1 %h %0d 0",
                         wb_wreg, wb_data, wb_rn, stall, rdata, rn);
            end
        end else begin
            if (wb_wreg !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL nowrite_wb: wb_wreg=%b stall=%b, required 0 0", wb_wreg, stall);
            end
        end
    endtask

    task automatic test_alu();
        alu_op(32'h0000_1234, 5'd5, 1'b1, 1'b0);
        alu_op(32'hCAFE_0001, 5'd31, 1'b0, 1'b0);
    endtask

    task automatic test_load();
        mem_op(32'h40, 32'h0, 1'b0, 5'd7, 3, 32'hDEAD_BEEF);
    endtask

    task automatic test_store();
        mem_op(32'h80, 32'h55, 1'b1, 5'd9, 1, 32'h1111_2222);
    endtask

    task automatic test_ack_vs_timeout();
        mem_op(32'h100, 32'h0, 1'b0, 5'd12, TO, 32'hA5A5_5A5A);
    endtask

    task automatic test_stray_ack();
        alu_op(32'h0BAD_0ACC, 5'd3, 1'b1, 1'b1);
        mem_op(32'h44, 32'h0, 1'b0, 5'd4, 2, 32'h1357_9BDF);
    endtask

    task automatic test_timeout();
        mem_op(32'h200, 32'h0, 1'b0, 5'd6, 0, 32'h0);
        alu_op(32'h7777_0000, 5'd1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: alu_op($urandom, 5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1: mem_op($urandom, $urandom, 1'b0, 5'($urandom),
                          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO)), $urandom);
                default: mem_op($urandom, $urandom, 1'b1, 5'($urandom),
                                int'($urandom_range(1, TO)), $urandom);
            endcase
        end
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        mem_result = 32'h300;
        mem_rb     = 32'h0;
        mem_wmem   = 1'b0;
        mem_m2reg  = 1'b1;
        mem_rn     = 5'd8;
        dm_ack     = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            drive_junk();
        end
        clr = 1'b1;
        #1;
        checks++;
        if (dm_req !== 1'b0 || stall !== 1'b0 || wb_wreg !== 1'b0 || bus_err !== 1'b0 || dm_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_wait: req=%b stall=%b wb_wreg=%b err=%b addr=%h, required all 0",
                     dm_req, stall, wb_wreg, bus_err, dm_addr);
        end
        @(negedge clk);
        clr = 1'b0;
        set_nop();
        exp_err = 1'b0;
        alu_op(32'h0000_4321, 5'd2, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_ack_vs_timeout();
        test_stray_ack();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles without dm_ack before abort.
REQ-002 SHALL have: clk  in  1  the single clock, rising edge.
REQ-003 SHALL have: clr  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have: mem_result  in  32  ALU result from the EXE/MEM register; this is the memory address or writeback value.
REQ-005 SHALL have: mem_rb  in  32  store data.
REQ-006 SHALL have: mem_wmem, mem_m2reg, mem_wreg  in  1 each  store, load-select and register-write controls.
REQ-007 SHALL have: mem_rn  in  5  destination register.
REQ-008 SHALL have: dm_req, dm_we  out  1 each  data-memory request and write enable.
REQ-009 SHALL have: dm_addr, dm_wdata  out  32 each  data-memory address and write data.
REQ-010 SHALL have: dm_rdata  in  32  read data; dm_ack  in  1  access complete.
REQ-011 SHALL have: stall  out  1  hold the EXE/MEM register and all upstream stages.
REQ-012 SHALL have: wb_data  out  32, wb_rn  out  5, wb_wreg  out  1  registered MEM/WB outputs.
REQ-013 SHALL have: bus_err  out  1  sticky timeout flag.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL treat a cycle as a memory op when mem_wmem|mem_m2reg=1 in IDLE; when both are set, the op is a store (no register write).
REQ-016 SHALL, for a non-memory op in IDLE: at the next edge load wb_data=mem_result, wb_rn=mem_rn, wb_wreg=mem_wreg; latency 1 cycle; stall=0.
REQ-017 SHALL, for a memory op in IDLE: latch address, data, we, rn and the load flag; go to WAIT; load wb_wreg=0 (bubble).
REQ-018 SHALL drive stall = (IDLE and memory op) or WAIT; combinational; 0 in RESP.
REQ-019 SHALL assert dm_req=1 only in WAIT, with dm_addr, dm_we and dm_wdata driven from latched values and stable until dm_ack.
REQ-020 SHALL, in WAIT on dm_ack=1: capture dm_rdata and go to RESP.
REQ-021 SHALL increment a WAIT-cycle counter, cleared on entry to WAIT.
REQ-022 SHALL, if the counter reaches TIMEOUT with dm_ack=0: set bus_err, capture data 0, mark the op aborted, and go to RESP.
REQ-023 SHALL give dm_ack priority over timeout when both occur in the same cycle.
REQ-024 SHALL, in RESP, at the edge: for a load, wb_data=captured rdata, wb_rn=latched rn, wb_wreg=1; for a store or aborted op, wb_wreg=0; then go to IDLE.
REQ-025 SHALL ignore the mem_* inputs in WAIT and RESP, so the held op never re-triggers.
REQ-026 SHALL ignore dm_ack outside WAIT.
REQ-027 SHALL keep bus_err at 1 until reset.
REQ-028 SHALL drive dm_addr, dm_wdata and dm_we to 0 when dm_req=0.

Reset
REQ-029 SHALL, while clr=1, immediately force: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, wb_data=0, wb_rn=0, wb_wreg=0, bus_err=0, counter=0, latches=0.
REQ-030 SHALL abort any in-flight access on reset with no writeback and dm_req deasserted asynchronously.
REQ-031 SHALL have stall=0 during reset.

Structure
REQ-032 SHALL take the FSM state encoding and the TIMEOUT default from a shared pipeline package.
REQ-033 SHALL place the WAIT counter and timeout compare in one sub-module, mem_ack_timer (inputs clk, clr, start, run; output expired).
REQ-034 SHALL keep all other logic flat in mem_access_unit.

Verification
REQ-035 SHALL cover: ALU op mem_result=0x0000_1234, mem_rn=5, mem_wreg=1 -> next edge wb_data=0x1234, wb_rn=5, wb_wreg=1, stall never 1.
REQ-036 SHALL cover: load addr 0x40, dm_ack on 3rd WAIT cycle with rdata 0xDEAD_BEEF -> stall high 4 cycles, dm_req high 3 cycles, after RESP wb_data=0xDEADBEEF, wb_wreg=1.
REQ-037 SHALL cover: store addr 0x80, data 0x55, dm_ack in 1st WAIT cycle -> dm_we=1, dm_wdata=0x55 while dm_req=1, wb_wreg=0 at RESP.
REQ-038 SHALL cover: load with no dm_ack, TIMEOUT=15 -> dm_req high exactly 15 cycles, bus_err=1 thereafter, wb_wreg=0.
REQ-039 SHALL cover: clr pulsed in 2nd WAIT cycle -> dm_req, stall and wb_wreg 0 immediately, state IDLE, next ALU op completes in 1 cycle.
REQ-040 SHALL cover: dm_ack and timeout in the same cycle, plus a stray dm_ack in IDLE -> ack wins with bus_err=0, and the stray ack causes no state change.
